// File: rtl/adder_word_sequencer.sv
// adder_word_sequencer: wide add/subtract built from one shared N-bit
// BinaryAdder, processed one N-bit slice per clock, LSB slice first.
// The carry between slices is held in a register; results are registered
// and held until the next accepted start or reset.

// BinaryAdder: N-bit ripple-carry adder shared by the sequencer.
module BinaryAdder #(
    parameter int n = 8
) (
    input  logic [n-1:0] A,
    input  logic [n-1:0] B,
    input  logic         Cin,
    output logic [n-1:0] Sum,
    output logic         Cout
);

    logic [n:0] w_c;

    assign w_c[0] = Cin;

    for (genvar g = 0; g < n; g++) begin : g_fa
        assign Sum[g]   = A[g] ^ B[g] ^ w_c[g];
        assign w_c[g+1] = (A[g] & B[g]) | (w_c[g] & (A[g] ^ B[g]));
    end

    assign Cout = w_c[n];

endmodule

module adder_word_sequencer #(
    parameter int N     = 8,
    parameter int WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 op_sub,
    input  logic [N*WORDS-1:0]   A,
    input  logic [N*WORDS-1:0]   B,
    input  logic                 Cin,
    output logic [N*WORDS-1:0]   Sum,
    output logic                 Cout,
    output logic                 Ovf,
    output logic                 busy,
    output logic                 done
);

    localparam int W  = N * WORDS;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                      r_state;
    logic [WORDS-1:0][N-1:0]     r_a;
    logic [WORDS-1:0][N-1:0]     r_b;
    logic                        r_sub;
    logic                        r_carry;
    logic [IW-1:0]               r_idx;
    logic [WORDS-1:0][N-1:0]     r_sum;
    logic                        r_cout;
    logic                        r_ovf;
    logic                        r_busy;
    logic                        r_done;

    logic [N-1:0]                w_a_slice;
    logic [N-1:0]                w_b_slice;
    logic [N-1:0]                w_sum_slice;
    logic                        w_cout;
    logic                        w_a_msb;
    logic                        w_beff_msb;
    logic                        w_ovf;

    // Slice selection: subtract feeds the inverted B slice, the +1 comes
    // from the carry register being preset to 1 on start.
    always_comb begin
        w_a_slice  = r_a[r_idx];
        w_b_slice  = r_b[r_idx] ^ {N{r_sub}};
        w_a_msb    = r_a[WORDS-1][N-1];
        w_beff_msb = r_b[WORDS-1][N-1] ^ r_sub;
        // On the last slice the adder output MSB is the final Sum[W-1].
        w_ovf      = (w_a_msb == w_beff_msb) && (w_sum_slice[N-1] != w_a_msb);
    end

    BinaryAdder #(.n(N)) u_adder (
        .A    (w_a_slice),
        .B    (w_b_slice),
        .Cin  (r_carry),
        .Sum  (w_sum_slice),
        .Cout (w_cout)
    );

    // Control FSM with registered datapath and handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_sub   <= 1'b0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a     <= A;
                        r_b     <= B;
                        r_sub   <= op_sub;
                        r_carry <= op_sub ? 1'b1 : Cin;
                        r_idx   <= '0;
                        r_sum   <= '0;
                        r_cout  <= 1'b0;
                        r_ovf   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_sum[r_idx] <= w_sum_slice;
                    r_carry      <= w_cout;
                    if (r_idx == LAST_IDX) begin
                        r_cout  <= w_cout;
                        r_ovf   <= w_ovf;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_idx <= r_idx + IW'(1);
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign Sum  = W'(r_sum);
    assign Cout = r_cout;
    assign Ovf  = r_ovf;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_adder_word_sequencer.sv
// Self-checking bench for adder_word_sequencer: directed cases plus random
// operations compared against a full-width arithmetic reference model.
module tb_adder_word_sequencer;

    localparam int N     = 8;
    localparam int WORDS = 4;
    localparam int W     = N * WORDS;

    logic         clk;
    logic         rst;
    logic         start;
    logic         op_sub;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Cin;
    logic [W-1:0] Sum;
    logic         Cout;
    logic         Ovf;
    logic         busy;
    logic         done;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    logic [W-1:0] exp_sum;
    logic         exp_cout;
    logic         exp_ovf;

    adder_word_sequencer #(.N(N), .WORDS(WORDS)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op_sub (op_sub),
        .A      (A),
        .B      (B),
        .Cin    (Cin),
        .Sum    (Sum),
        .Cout   (Cout),
        .Ovf    (Ovf),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Reference: plain W-bit arithmetic on the whole operands.
    function automatic void ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                      input logic cin, input logic sub,
                                      output logic [W-1:0] s, output logic co,
                                      output logic ov);
        logic [W:0] t;
        if (sub) begin
            t  = {1'b0, a} - {1'b0, b};
            s  = t[W-1:0];
            co = (a >= b);
            ov = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
        end else begin
            t  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
            s  = t[W-1:0];
            co = t[W];
            ov = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
        end
    endfunction

    // Issue one operation from IDLE/DONE and check timing and result.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic sub, input bit noise);
        logic [W-1:0] es;
        logic eco, eov;
        ref_model(a, b, cin, sub, es, eco, eov);
        A = a; B = b; Cin = cin; op_sub = sub; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        A = W'($urandom); B = W'($urandom); Cin = 1'($urandom); op_sub = 1'($urandom);
        check_val("busy_acc", W'(busy), W'(1));
        check_val("done_acc", W'(done), W'(0));
        for (int i = 1; i <= WORDS; i++) begin
            if (noise && i == 1) begin
                start = 1'b1;
                A = W'($urandom); B = W'($urandom); op_sub = ~sub;
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (i < WORDS) begin
                check_val("busy_run", W'(busy), W'(1));
                check_val("done_run", W'(done), W'(0));
            end else begin
                check_val("busy_end", W'(busy), W'(0));
                check_val("done_end", W'(done), W'(1));
                check_val("sum", Sum, es);
                check_val("cout", W'(Cout), W'(eco));
                check_val("ovf", W'(Ovf), W'(eov));
            end
        end
        exp_sum = es; exp_cout = eco; exp_ovf = eov;
    endtask

    task automatic idle_cycles(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            A = W'($urandom); B = W'($urandom); Cin = 1'($urandom); op_sub = 1'($urandom);
            @(posedge clk); #1;
            check_val("hold_sum", Sum, exp_sum);
            check_val("hold_cout", W'(Cout), W'(exp_cout));
            check_val("hold_ovf", W'(Ovf), W'(exp_ovf));
            check_val("hold_busy", W'(busy), W'(0));
            check_val("hold_done", W'(done), W'(0));
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op_sub = 1'b0; A = '0; B = '0; Cin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_sum", Sum, W'(0));
        check_val("rst_cout", W'(Cout), W'(0));
        check_val("rst_ovf", W'(Ovf), W'(0));
        check_val("rst_busy", W'(busy), W'(0));
        check_val("rst_done", W'(done), W'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed adds
        run_op(32'h000000FF, 32'h00000001, 1'b0, 1'b0, 1'b0);
        check_val("t1_sum", exp_sum, 32'h00000100);
        idle_cycles(1);
        run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0);
        idle_cycles(1);
        run_op(32'h7FFFFFFF, 32'h00000000, 1'b1, 1'b0, 1'b0);
        idle_cycles(1);

        // Directed subtracts (Cin ignored)
        run_op(32'd5, 32'd7, 1'b1, 1'b1, 1'b0);
        idle_cycles(1);
        run_op(32'd7, 32'd5, 1'b0, 1'b1, 1'b0);
        idle_cycles(1);
        run_op(32'h80000000, 32'd1, 1'b0, 1'b1, 1'b0);
        idle_cycles(1);

        // Start during RUN ignored, then back-to-back from the done cycle
        run_op(32'h01020304, 32'h10203040, 1'b0, 1'b0, 1'b1);
        run_op(32'd1, 32'd2, 1'b0, 1'b0, 1'b0);
        idle_cycles(1);

        // Reset on the second RUN edge discards the partial result
        A = 32'h12345678; B = 32'h11111111; Cin = 1'b0; op_sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_val("mrst_sum", Sum, W'(0));
        check_val("mrst_cout", W'(Cout), W'(0));
        check_val("mrst_ovf", W'(Ovf), W'(0));
        check_val("mrst_busy", W'(busy), W'(0));
        check_val("mrst_done", W'(done), W'(0));
        run_op(32'h12345678, 32'h11111111, 1'b0, 1'b0, 1'b0);

        // Idle hold with changing inputs
        idle_cycles(10);

        // Random operations with random gaps, back-to-back and RUN noise
        for (int k = 0; k < 40; k++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
                   ($urandom_range(0, 3) == 0));
            idle_cycles($urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
